// File: rtl/rsa_exp_ctrl.sv
// Sequencer for y^d mod N: right-to-left square-and-multiply over the exponent bits,
// driving one shared Montgomery multiplier through a start/ready handshake.
module rsa_exp_ctrl #(
  parameter int W = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_N,
  input  logic [W-1:0] i_t,
  input  logic [W-1:0] i_d,
  output logic         o_busy,
  output logic         o_ready,
  output logic [W-1:0] o_result,
  output logic         o_mont_start,
  output logic [W-1:0] o_mont_a,
  output logic [W-1:0] o_mont_b,
  output logic [W-1:0] o_mont_N,
  input  logic         i_mont_ready,
  input  logic [W-1:0] i_mont_m
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MUL_REQ  = 3'd1;
  localparam logic [2:0] S_MUL_WAIT = 3'd2;
  localparam logic [2:0] S_SQR_REQ  = 3'd3;
  localparam logic [2:0] S_SQR_WAIT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [KW-1:0] k, k_inc;
  logic [W-1:0]  m, t, d;
  logic [W-1:0]  m_nxt, t_nxt;
  logic          accept;

  assign accept = (state == S_IDLE) && i_start;
  assign k_inc  = k + KW'(1);

  // m stays in the normal domain (m * tR * R^-1 = m*y); t stays in Montgomery form.
  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    t_nxt     = t;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          m_nxt     = W'(1);
          t_nxt     = i_t;
          state_nxt = i_d[0] ? S_MUL_REQ : S_SQR_REQ;
        end
      end
      S_MUL_REQ:  state_nxt = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (i_mont_ready) begin
          m_nxt     = i_mont_m;
          state_nxt = (k == K_LAST) ? S_DONE : S_SQR_REQ;
        end
      end
      S_SQR_REQ:  state_nxt = S_SQR_WAIT;
      S_SQR_WAIT: begin
        if (i_mont_ready) begin
          t_nxt = i_mont_m;
          if (d[k_inc])
            state_nxt = S_MUL_REQ;
          else if (k_inc < K_LAST)
            state_nxt = S_SQR_REQ;
          else
            state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        k <= '0;
      else if ((state == S_SQR_WAIT) && i_mont_ready)
        k <= k_inc;
    end
  end

  // Operands are loaded on entry to a request state so they are stable for the whole wait.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result <= '0;
      o_mont_a <= '0;
      o_mont_b <= '0;
      o_mont_N <= '0;
    end else begin
      if (accept)
        o_mont_N <= i_N;
      if (state_nxt == S_MUL_REQ) begin
        o_mont_a <= m_nxt;
        o_mont_b <= t_nxt;
      end else if (state_nxt == S_SQR_REQ) begin
        o_mont_a <= t_nxt;
        o_mont_b <= t_nxt;
      end
      if (state_nxt == S_DONE)
        o_result <= m_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    m <= m_nxt;
    t <= t_nxt;
    if (accept)
      d <= i_d;
  end

  assign o_busy       = (state != S_IDLE);
  assign o_ready      = (state == S_DONE);
  assign o_mont_start = (state == S_MUL_REQ) || (state == S_SQR_REQ);

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl: an 8-bit and a 256-bit instance share one Montgomery multiplier model
// with variable latency; results are compared with plain modular exponentiation.
module tb_rsa_exp_ctrl;
  localparam int WB = 256;
  localparam int WS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, sel8;
  logic [WB-1:0] in_n, in_t, in_d;
  logic          model_rdy, stray_rdy;
  logic [WB-1:0] model_m, stray_m, mont_m;
  logic          mrdy;

  assign mrdy   = model_rdy | stray_rdy;
  assign mont_m = stray_rdy ? stray_m : model_m;

  logic          busy8, rdy8, ms8;
  logic [WS-1:0] res8, a8, b8, n8;
  logic          busyw, rdyw, msw;
  logic [WB-1:0] resw, aw, bw, nw;

  rsa_exp_ctrl #(.W(WS)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start & sel8),
    .i_N(in_n[WS-1:0]), .i_t(in_t[WS-1:0]), .i_d(in_d[WS-1:0]),
    .o_busy(busy8), .o_ready(rdy8), .o_result(res8),
    .o_mont_start(ms8), .o_mont_a(a8), .o_mont_b(b8), .o_mont_N(n8),
    .i_mont_ready(mrdy & sel8), .i_mont_m(mont_m[WS-1:0])
  );

  rsa_exp_ctrl #(.W(WB)) dutw (
    .i_clk(clk), .i_rst(rst), .i_start(start & ~sel8),
    .i_N(in_n), .i_t(in_t), .i_d(in_d),
    .o_busy(busyw), .o_ready(rdyw), .o_result(resw),
    .o_mont_start(msw), .o_mont_a(aw), .o_mont_b(bw), .o_mont_N(nw),
    .i_mont_ready(mrdy & ~sel8), .i_mont_m(mont_m)
  );

  logic          busy, rdy, mst;
  logic [WB-1:0] res, ma, mb, mn;
  assign busy = sel8 ? busy8 : busyw;
  assign rdy  = sel8 ? rdy8  : rdyw;
  assign mst  = sel8 ? ms8   : msw;
  assign res  = sel8 ? WB'(res8) : resw;
  assign ma   = sel8 ? WB'(a8)   : aw;
  assign mb   = sel8 ? WB'(b8)   : bw;
  assign mn   = sel8 ? WB'(n8)   : nw;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WB-1:0] mont_mul(input logic [WB-1:0] a, b, n, input int w);
    logic [WB+1:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (a[i]) r = r + {2'b00, b};
      if (r[0]) r = r + {2'b00, n};
      r = r >> 1;
    end
    if (r >= {2'b00, n}) r = r - {2'b00, n};
    return r[WB-1:0];
  endfunction

  function automatic logic [WB-1:0] to_mont(input logic [WB-1:0] y, n, input int w);
    logic [2*WB-1:0] v;
    v = {{WB{1'b0}}, y} << w;
    v = v % {{WB{1'b0}}, n};
    return v[WB-1:0];
  endfunction

  function automatic logic [WB-1:0] modexp(input logic [WB-1:0] y, d, n, input int w);
    logic [2*WB-1:0] r, b, nn;
    nn = {{WB{1'b0}}, n};
    r  = 1;
    b  = {{WB{1'b0}}, y} % nn;
    for (int i = 0; i < w; i++) begin
      if (d[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[WB-1:0];
  endfunction

  function automatic logic [WB-1:0] rand256();
    logic [WB-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Multiplier model: ready for one cycle, L cycles after the request cycle
  int lat_mode = 0, lat_fix = 1, lat_cnt = 0, lat_sum = 0;
  int n_req = 0, n_neq = 0, n_badn = 0, n_unstable = 0;
  logic [WB-1:0] cap_a, cap_b, pend, last_a, last_b, exp_n;
  logic last_sq = 1'b0;

  function automatic int pick_lat();
    if (lat_mode == 0) return lat_fix;
    if (lat_mode == 1) return ($urandom_range(0, 127) == 0) ? int'($urandom_range(2, 300)) : 1;
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 300)) : int'($urandom_range(1, 3));
  endfunction

  initial begin
    model_rdy = 1'b0;
    model_m   = '0;
  end

  always @(negedge clk) begin
    model_rdy = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        if (ma !== cap_a || mb !== cap_b) n_unstable++;
        model_rdy = 1'b1;
        model_m   = pend;
      end
    end
    if (mst) begin
      cap_a   = ma;
      cap_b   = mb;
      pend    = mont_mul(ma, mb, mn, sel8 ? WS : WB);
      lat_cnt = pick_lat();
      lat_sum += lat_cnt;
      n_req++;
      if (ma != mb) n_neq++;
      if (mn != exp_n) n_badn++;
      last_a  = ma;
      last_b  = mb;
      last_sq = (ma == mb);
    end
  end

  task automatic reset_chk(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_ready"}, rdy, 0);
    check_val({tag, "_mstart"}, mst, 0);
    check_val({tag, "_result"}, res, 0);
    check_val({tag, "_a"}, ma, 0);
    check_val({tag, "_b"}, mb, 0);
    check_val({tag, "_n"}, mn, 0);
  endtask

  task automatic run_exp(input bit w8, input logic [WB-1:0] n, y, d, input int lmode, lfix,
                         input bit inj, input string tag, output int cyc, output logic [WB-1:0] res_out);
    int w, ops, lim;
    bit got, injd;
    logic [WB-1:0] expr;
    w    = w8 ? WS : WB;
    expr = modexp(y, d, n, w);
    ops  = $countones(d) + w - 1;
    lim  = 2 + ops * 302;
    @(negedge clk);
    sel8 = w8; lat_mode = lmode; lat_fix = lfix; exp_n = n;
    n_req = 0; n_neq = 0; n_badn = 0; n_unstable = 0; lat_sum = 0;
    in_n = n; in_t = to_mont(y, n, w); in_d = d; start = 1'b1;
    cyc = 0; got = 0; injd = 0;
    while (!got && cyc < lim) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) check_val({tag, "_busy_on"}, busy, 1);
      if (inj && !injd && !mst && lat_cnt > 0 && last_sq) begin
        start = 1'b1; in_d = ~d; in_n = n ^ 2; in_t = '0; injd = 1;
      end
      if (rdy) got = 1;
    end
    res_out = res;
    check_val({tag, "_ready_seen"}, got, 1);
    if (got) begin
      check_val({tag, "_result"}, res, expr);
      check_val({tag, "_ops"}, n_req, ops);
      check_val({tag, "_ready_cycle"}, cyc, 1 + n_req + lat_sum);
      check_val({tag, "_busy_done"}, busy, 1);
      check_val({tag, "_opnd_n"}, n_badn, 0);
      check_val({tag, "_opnd_stable"}, n_unstable, 0);
      @(negedge clk);
      check_val({tag, "_ready_pulse"}, rdy, 0);
      check_val({tag, "_busy_off"}, busy, 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;
    logic [WB-1:0] r, n, y, d;
    rst = 1'b1; start = 1'b0; sel8 = 1'b1;
    in_n = '0; in_t = '0; in_d = '0;
    stray_rdy = 1'b0; stray_m = '0; exp_n = '0;
    repeat (3) @(negedge clk);
    reset_chk("rst8");
    sel8 = 1'b0;
    reset_chk("rst256");
    rst = 1'b0;

    // W=8, N=13, y=2 (t=5), d=5, L=3
    check_val("tomont_5", to_mont(2, 13, WS), 5);
    run_exp(1, 13, 2, 5, 0, 3, 0, "d5", cyc, r);
    check_val("d5_res6", r, 6);
    check_val("d5_cyc37", cyc, 37);
    check_val("d5_pulses9", n_req, 9);

    // stray ready in idle, then start pulsed during a square wait
    @(negedge clk);
    stray_m = 8'hAB; stray_rdy = 1'b1;
    @(negedge clk);
    stray_rdy = 1'b0;
    check_val("stray_idle_busy", busy, 0);
    check_val("stray_idle_res", res, 6);
    @(negedge clk);
    check_val("stray_idle_ready", rdy, 0);
    run_exp(1, 13, 2, 5, 0, 3, 1, "inj", cyc, r);
    check_val("inj_res6", r, 6);
    check_val("inj_pulses9", n_req, 9);

    // top bit only: the last request is a multiply with a=m=1 and nothing follows
    run_exp(1, 13, 2, 8'h80, 0, 2, 0, "d80", cyc, r);
    check_val("d80_pulses", n_req, 8);
    check_val("d80_last_a", last_a, 1);
    check_val("d80_last_b", last_b, to_mont(modexp(2, 128, 13, WS), 13, WS));

    // W=256, d=0 and d=1
    n = rand256() | 1 | (WB'(1) << (WB - 1));
    y = (rand256() % n) | 2;
    run_exp(0, n, y, 0, 0, 1, 0, "w256_d0", cyc, r);
    check_val("w256_d0_one", r, 1);
    check_val("w256_d0_sq", n_req, 255);
    check_val("w256_d0_nomul", n_neq, 0);
    run_exp(0, n, y, 1, 0, 1, 0, "w256_d1", cyc, r);
    check_val("w256_d1_y", r, y);

    // reset mid-run, stray ready afterwards, then a fresh run
    @(negedge clk);
    sel8 = 1'b1; lat_mode = 0; lat_fix = 3; exp_n = 13;
    in_n = 13; in_t = 5; in_d = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_val("midrst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_chk("midrst");
    stray_m = 8'h07; stray_rdy = 1'b1;
    @(negedge clk);
    stray_rdy = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rdy || busy || mst) seen = 1;
    end
    check_val("midrst_quiet", seen, 0);
    run_exp(1, 13, 2, 3, 0, 3, 0, "postrst", cyc, r);
    check_val("postrst_res8", r, 8);

    // random W=8 with occasional long latencies
    for (int i = 0; i < 40; i++) begin
      n = WB'({$urandom_range(1, 127), 1'b1});
      y = WB'($urandom()) % n;
      d = WB'($urandom_range(0, 255));
      run_exp(1, n, y, d, 2, 1, (i % 5) == 0, "rnd8", cyc, r);
    end

    // random W=256 odd moduli
    for (int i = 0; i < 16; i++) begin
      n = rand256() | 1 | (WB'(1) << (WB - 1));
      y = rand256() % n;
      d = rand256();
      run_exp(0, n, y, d, 1, 1, 0, "rnd256", cyc, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
